// File: rtl/fsm_seq_generator_if.sv
// Serial pattern transmitter bus: start/data/repeat_cnt request side and x/x_valid/busy/done status side.
interface fsm_seq_generator_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] repeat_cnt;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, data, repeat_cnt,
    input  x, x_valid, busy, done
  );

  modport slave (
    input  start, data, repeat_cnt,
    output x, x_valid, busy, done
  );
endinterface

// File: rtl/fsm_seq_generator.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first for repeat_cnt+1 frames.
// Define SEQGEN_GAP_EN to insert a one-cycle idle gap between consecutive frames.
module fsm_seq_generator #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  fsm_seq_generator_if.slave  bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

`ifdef SEQGEN_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t           state, state_next;
  logic [WIDTH-1:0] pattern, pattern_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [BW-1:0]    bit_cnt, bit_next;
  logic [CNT_W-1:0] frame_cnt, frame_next;
  logic             x_q, x_valid_q, busy_q, done_q;
  logic             x_next, x_valid_next, busy_next, done_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pattern   <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      pattern   <= pattern_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_next;
      frame_cnt <= frame_next;
      x_q       <= x_next;
      x_valid_q <= x_valid_next;
      busy_q    <= busy_next;
      done_q    <= done_next;
    end
  end

  // shift_reg[MSB] is the bit on x while in SHIFT; bit_cnt counts the bits still to follow it
  always_comb begin
    state_next   = state;
    pattern_next = pattern;
    shift_next   = shift_reg;
    bit_next     = bit_cnt;
    frame_next   = frame_cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          pattern_next = bus.data;
          shift_next   = bus.data;
          bit_next     = LAST_BIT;
          frame_next   = bus.repeat_cnt;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          if (frame_cnt != '0) begin
            frame_next = frame_cnt - 1'b1;
            shift_next = pattern;
            bit_next   = LAST_BIT;
`ifdef SEQGEN_GAP_EN
            state_next = GAP;
`else
            state_next = SHIFT;
`endif
          end else begin
            state_next = DONE;
          end
        end else begin
          shift_next = {shift_reg[WIDTH-2:0], 1'b0};
          bit_next   = bit_cnt - 1'b1;
        end
      end
`ifdef SEQGEN_GAP_EN
      GAP:     state_next = SHIFT;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they land in flops aligned with it
  always_comb begin
    x_next       = 1'b0;
    x_valid_next = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    if (state_next == SHIFT) begin
      x_next       = shift_next[WIDTH-1];
      x_valid_next = 1'b1;
      busy_next    = 1'b1;
    end
`ifdef SEQGEN_GAP_EN
    if (state_next == GAP) begin
      busy_next = 1'b1;
    end
`endif
    if (state_next == DONE) begin
      done_next = 1'b1;
    end
  end

  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: doc/fsm_seq_generator.md
Name: fsm_seq_generator

Overview:
Serial pattern transmitter that drives the 1-bit stream consumed by fsm_seq_detector. It latches a WIDTH-bit pattern on a start pulse and shifts it out MSB-first, one bit per clk, for a programmable number of back-to-back frames. It reports busy/done status. It sits upstream of the detector's x input as the stimulus/transmit side of the serial sequence link.

Parameters:
WIDTH, 5, pattern length in bits; matches the detector's data width.
CNT_W, 4, width of the repeat-count input; frames sent = repeat_cnt + 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk)
start  input  1  request to begin transmission; sampled only in IDLE
data  input  WIDTH  pattern to transmit; latched when start is accepted
repeat_cnt  input  CNT_W  additional frames after the first; latched with data
x  output  1  serial bit stream to the detector
x_valid  output  1  high while x carries a pattern bit
busy  output  1  high from the cycle after start is accepted through the last bit
done  output  1  one-cycle pulse after the final bit of the final frame

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; x=0, x_valid=0, busy=0, done=0; shift register, bit counter and frame counter cleared. Takes effect mid-frame with no completion pulse.
- All outputs are registered.
- States: IDLE, SHIFT, GAP (only with the optional feature), DONE.
- IDLE: x=0, x_valid=0, busy=0. If start=1 at a clk edge:
  - latch data into shift register, repeat_cnt into frame counter, bit counter=WIDTH-1;
  - go to SHIFT.
- SHIFT:
  - Each cycle x=shift_reg[WIDTH-1], x_valid=1, busy=1; shift left by one and decrement the bit counter.
  - First bit appears on x the cycle after the start edge (latency 1).
  - When the bit counter reaches 0 and the frame counter is nonzero: decrement the frame counter, reload the shift register from the latched pattern, bit counter=WIDTH-1. With the gap feature, go to GAP; otherwise stay in SHIFT so the next frame is contiguous with no idle cycle.
  - When the bit counter reaches 0 and the frame counter is 0: go to DONE.
- DONE: one cycle; done=1, busy=0, x=0, x_valid=0; then IDLE. start is ignored in DONE. A new start is accepted in the following IDLE cycle at the earliest.
- start while busy or in DONE is ignored; it is not queued.
- data and repeat_cnt changes after acceptance have no effect on the current transmission.
- Total bits per transmission = WIDTH*(repeat_cnt+1). Counters never wrap: the maximum repeat_cnt of 2^CNT_W-1 gives 2^CNT_W frames.
- Simultaneous start at a reset release edge: reset dominates while rst=0. start is first sampled at the first clk edge with rst=1.

Optional Feature:
SEQGEN_GAP_EN
- Defined: a GAP state is inserted between consecutive frames. It lasts exactly one cycle with x=0, x_valid=0, busy=1. No gap follows the final frame; the last frame goes directly to DONE.
- Undefined: the GAP state and its logic are not compiled, and frames are contiguous.

Test Plan:
- Single frame: release rst, data=5'b11100, repeat_cnt=0, one-cycle start -> x = 1,1,1,0,0 on cycles 1-5 after the start edge; x_valid=1 on those cycles; busy=1 on cycles 1-5; done=1 on cycle 6 only; IDLE on cycle 7.
- Repeat: data=5'b10110, repeat_cnt=2 -> 15 contiguous valid bits 10110 10110 10110, then a single done pulse. With SEQGEN_GAP_EN: 17 cycles, with x_valid=0 on cycles 6 and 12.
- Ignore start: assert start again on cycle 3 of a transmission with different data -> original pattern completes unchanged; no second transmission follows.
- Reset mid-frame: pull rst low asynchronously between edges during bit 3 -> x, x_valid and busy go to 0 immediately; no done pulse. After release, a new start transmits a full frame correctly.
- Loopback: connect x to fsm_seq_detector x, with the same data=5'b11100 on both -> the detector's z asserts once per transmitted frame at the final bit of each frame.
- Back-to-back: new start in the first IDLE cycle after done, data=5'b00001 -> output 0,0,0,0,1 with latency 1; done timing identical to the single-frame case.
